// File: rtl/alu_sched_pkg.sv
// Shared definitions for the two-requester ALU scheduler.
//   DEF_*   : default widths/limits used by alu_req_scheduler parameters
//   state_t : scheduler FSM states (IDLE -> ISSUE -> RESP -> IDLE)
//   req_t   : one request record {sel, a, b, cin} at the default widths
package alu_sched_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_SEL_W   = 5;
  localparam int DEF_NUM_OPS = 20;
  localparam int DEF_ALU_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_SEL_W-1:0]  sel;
    logic [DEF_DATA_W-1:0] a;
    logic [DEF_DATA_W-1:0] b;
    logic                  cin;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : requesters currently asking
//   advance  : the current grant was taken; remember who won
//   gnt[1:0] : one-hot grant (zero when nobody asks)
// After reset requester 1 counts as the last winner, so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_p0 <= 1'b1;
    end else if (advance) begin
      last_p0 <= gnt[1];
    end
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_p0 ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one combinational ALU between two requesters.
//   req{0,1}_*  : valid/ready request channels (sel, a, b, cin)
//   rsp{0,1}_*  : valid/ready response channels (y, cout, err)
//   alu_*       : registered operands to the ALU, result/carry back from it
// One operation in flight at a time: accept in IDLE, hold operands for ALU_LAT cycles
// in ISSUE, present the captured result in RESP until the owner takes it.
// Illegal select codes skip ISSUE and answer err=1, y=0, cout=0.
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int NUM_OPS = DEF_NUM_OPS,
  parameter int ALU_LAT = DEF_ALU_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_cin,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_cin,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_y,
  output logic              rsp0_cout,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_y,
  output logic              rsp1_cout,
  output logic              rsp1_err,
  output logic [SEL_W-1:0]  alu_select,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_cout
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  function automatic logic sel_illegal(input logic [SEL_W-1:0] sel);
    return {1'b0, sel} >= (SEL_W + 1)'(NUM_OPS);
  endfunction

  state_t            state, state_nxt;
  logic [1:0]        gnt;
  logic              accept;
  logic              rsp_hs;
  logic [SEL_W-1:0]  acc_sel;
  logic [DATA_W-1:0] acc_a;
  logic [DATA_W-1:0] acc_b;
  logic              acc_cin;
  logic              acc_bad;

  logic              gid_p1;
  logic [CNT_W-1:0]  cnt_p1;
  logic [DATA_W-1:0] y_p2;
  logic              cout_p2;
  logic              err_p2;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .advance (accept),
    .gnt     (gnt)
  );

  // Readies are forced low while reset is held so nothing is accepted then.
  always_comb begin
    req0_ready = (state == IDLE) && !rst && gnt[0];
    req1_ready = (state == IDLE) && !rst && gnt[1];
    accept     = req0_ready || req1_ready;
    acc_sel    = gnt[1] ? req1_sel : req0_sel;
    acc_a      = gnt[1] ? req1_a   : req0_a;
    acc_b      = gnt[1] ? req1_b   : req0_b;
    acc_cin    = gnt[1] ? req1_cin : req0_cin;
    acc_bad    = sel_illegal(acc_sel);
    rsp_hs     = (state == RESP) && (gid_p1 ? rsp1_ready : rsp0_ready);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = acc_bad ? RESP : ISSUE;
      ISSUE:   if (cnt_p1 == '0) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gid_p1     <= 1'b0;
      cnt_p1     <= '0;
      alu_select <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      y_p2       <= '0;
      cout_p2    <= 1'b0;
      err_p2     <= 1'b0;
    end else begin
      // Stage p1: grant id and operands registered on accept; alu_* hold afterwards.
      if (accept) begin
        gid_p1 <= gnt[1];
        if (acc_bad) begin
          y_p2    <= '0;
          cout_p2 <= 1'b0;
          err_p2  <= 1'b1;
        end else begin
          alu_select <= acc_sel;
          alu_a      <= acc_a;
          alu_b      <= acc_b;
          alu_cin    <= acc_cin;
          cnt_p1     <= CNT_W'(ALU_LAT - 1);
        end
      end
      // Stage p2: result captured on the last settle cycle.
      if (state == ISSUE) begin
        if (cnt_p1 == '0) begin
          y_p2    <= alu_y;
          cout_p2 <= alu_cout;
          err_p2  <= 1'b0;
        end else begin
          cnt_p1 <= cnt_p1 - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rsp0_valid = (state == RESP) && !gid_p1;
    rsp1_valid = (state == RESP) && gid_p1;
    rsp0_y     = y_p2;
    rsp1_y     = y_p2;
    rsp0_cout  = cout_p2;
    rsp1_cout  = cout_p2;
    rsp0_err   = err_p2;
    rsp1_err   = err_p2;
  end

endmodule
